// File: rtl/sparc_tlu_intpend64_if.sv
// ---------------------------------------------------------------------------
// sparc_tlu_intpend64_if
//
// Bundles the pending-interrupt block's bus so that the block, the priority
// encoder and the trap logic can be wired up in one connection.
//
//   set_vec    [63:0] per-bit set requests (one-cycle pulses, multi-hot ok)
//   sw_clr_vld        software clear strobe
//   sw_clr_idx  [5:0] bit cleared when sw_clr_vld=1
//   mask       [63:0] per-bit enable; only enabled bits compete
//   pend_vec   [63:0] pend_q & mask, feeds the external 64->6 encoder
//   penc_idx    [5:0] encoder result for pend_vec (same cycle)
//   pend_q     [63:0] raw pending register
//   pend_any          |pend_vec
//   disp_vld          registered dispatch request
//   disp_idx    [5:0] registered index being dispatched
//   disp_ack          trap logic accepts the current dispatch
//   to_pulse          one-cycle pulse when a dispatch is withdrawn on timeout
//
// Modports: "slave" is the pending block itself, "master" is its
// environment (interrupt sources, encoder and trap logic).
// ---------------------------------------------------------------------------
interface sparc_tlu_intpend64_if;
    logic [63:0] set_vec;
    logic        sw_clr_vld;
    logic [5:0]  sw_clr_idx;
    logic [63:0] mask;
    logic [63:0] pend_vec;
    logic [5:0]  penc_idx;
    logic [63:0] pend_q;
    logic        pend_any;
    logic        disp_vld;
    logic [5:0]  disp_idx;
    logic        disp_ack;
    logic        to_pulse;

    modport slave (
        input  set_vec, sw_clr_vld, sw_clr_idx, mask, penc_idx, disp_ack,
        output pend_vec, pend_q, pend_any, disp_vld, disp_idx, to_pulse
    );

    modport master (
        output set_vec, sw_clr_vld, sw_clr_idx, mask, penc_idx, disp_ack,
        input  pend_vec, pend_q, pend_any, disp_vld, disp_idx, to_pulse
    );
endinterface

// File: rtl/sparc_tlu_intpend64.sv
// ---------------------------------------------------------------------------
// sparc_tlu_intpend64
//
// 64-entry pending-interrupt holding register with a dispatch sequencer.
// The masked pending vector is handed to an external 64->6 priority encoder
// (bit 63 highest); the encoded winner is captured and offered to the trap
// logic over a valid/ack handshake, one request at a time. The serviced bit
// is cleared on ack. A request is withdrawn (bit left pending) if its mask
// bit drops, its pending bit is cleared by software, or it stays
// unacknowledged for ACK_TIMEOUT cycles (0 disables the timeout).
//
// Ports:
//   rclk    clock
//   arst_l  asynchronous active-low reset
//   bus     sparc_tlu_intpend64_if.slave (see interface header for signals)
//
// Parameters:
//   ACK_TIMEOUT  cycles disp_vld may stay unacknowledged; 0 = never
//   TO_W         timeout counter width, ACK_TIMEOUT < 2**TO_W
// ---------------------------------------------------------------------------
module sparc_tlu_intpend64 #(
    parameter int ACK_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic                 rclk,
    input  logic                 arst_l,
    sparc_tlu_intpend64_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam bit            TO_EN   = (ACK_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(ACK_TIMEOUT - 1) : '0;

    state_t            state_q;
    logic [63:0]       pend_bits_q;
    logic [63:0]       pend_bits_d;
    logic [63:0]       pend_vis;
    logic [63:0]       clr;
    logic              disp_vld_q;
    logic [5:0]        disp_idx_q;
    logic              to_pulse_q;
    logic [TO_W-1:0]   cnt_q;
    logic              ack_clr;
    logic              cur_live;

    assign pend_vis = pend_bits_q & bus.mask;

    // An ack only counts while a request is actually outstanding.
    assign ack_clr  = (state_q == REQ) && bus.disp_ack;

    // The dispatched bit is still worth presenting only while it is both
    // pending and enabled.
    assign cur_live = bus.mask[disp_idx_q] && pend_bits_q[disp_idx_q];

    // Per-bit next state. The set term is OR-ed in last so a set arriving in
    // the same cycle as an ack or software clear of that bit is never lost.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_bit
            localparam logic [5:0] BIT_IDX = 6'(gi);
            assign clr[gi] = (ack_clr && (disp_idx_q == BIT_IDX)) ||
                             (bus.sw_clr_vld && (bus.sw_clr_idx == BIT_IDX));
            assign pend_bits_d[gi] = bus.set_vec[gi] | (pend_bits_q[gi] & ~clr[gi]);
        end
    endgenerate

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            pend_bits_q <= '0;
        end else begin
            pend_bits_q <= pend_bits_d;
        end
    end

    // Dispatch sequencer. No re-arbitration while in REQ: a higher-priority
    // arrival waits for the current request to be acked or withdrawn.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= IDLE;
            disp_vld_q <= 1'b0;
            disp_idx_q <= '0;
            to_pulse_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            to_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // penc_idx is only meaningful while something is visible.
                    if (|pend_vis) begin
                        state_q    <= REQ;
                        disp_vld_q <= 1'b1;
                        disp_idx_q <= bus.penc_idx;
                        cnt_q      <= '0;
                    end
                end
                REQ: begin
                    if (bus.disp_ack) begin
                        // Ack beats withdrawal; the bit clear happens in
                        // the pending register via ack_clr.
                        state_q    <= IDLE;
                        disp_vld_q <= 1'b0;
                    end else if (!cur_live) begin
                        state_q    <= IDLE;
                        disp_vld_q <= 1'b0;
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        state_q    <= IDLE;
                        disp_vld_q <= 1'b0;
                        to_pulse_q <= 1'b1;
                    end else if (TO_EN) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    disp_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pend_vec = pend_vis;
    assign bus.pend_q   = pend_bits_q;
    assign bus.pend_any = |pend_vis;
    assign bus.disp_vld = disp_vld_q;
    assign bus.disp_idx = disp_idx_q;
    assign bus.to_pulse = to_pulse_q;

endmodule

// File: tb/tb_sparc_tlu_intpend64.sv
// ---------------------------------------------------------------------------
// tb_sparc_tlu_intpend64
//
// Directed scenarios with fixed expectations followed by a randomized run
// checked against a reference model of the pending set and the single
// outstanding dispatch. The bench also plays the external priority encoder.
// ---------------------------------------------------------------------------
module tb_sparc_tlu_intpend64;

    localparam int TIMEOUT = 4;

    logic rclk = 1'b0;
    logic arst_l;

    int n_checks = 0;
    int n_errors = 0;

    sparc_tlu_intpend64_if bus();

    sparc_tlu_intpend64 #(
        .ACK_TIMEOUT(TIMEOUT),
        .TO_W(8)
    ) dut (
        .rclk(rclk),
        .arst_l(arst_l),
        .bus(bus)
    );

    always #5 rclk = ~rclk;

    // Highest set bit, 0 when empty.
    function automatic int top_bit(input logic [63:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 64; i++) if (v[i]) r = i;
        return r;
    endfunction

    // External priority encoder.
    always_comb bus.penc_idx = 6'(top_bit(bus.pend_vec));

    // ---------------- reference model ----------------
    // m_pend : set of pending interrupts
    // m_busy : a dispatch is being offered; m_idx is its index
    // m_age  : number of cycles the current offer has been visible
    // m_to   : timeout withdrawal reported this cycle
    logic [63:0] m_pend;
    bit          m_busy;
    int          m_idx;
    int          m_age;
    bit          m_to;

    task automatic model_reset();
        m_pend = '0;
        m_busy = 0;
        m_idx  = 0;
        m_age  = 0;
        m_to   = 0;
    endtask

    task automatic drive_idle();
        bus.set_vec    = '0;
        bus.sw_clr_vld = 1'b0;
        bus.sw_clr_idx = '0;
        bus.mask       = '1;
        bus.disp_ack   = 1'b0;
    endtask

    // Advance one clock, update the model from the inputs that were applied,
    // and return 1 time unit after the edge.
    task automatic tick();
        logic [63:0] nxt;
        logic [63:0] visible;
        bit          acked;
        @(posedge rclk);
        if (!arst_l) begin
            model_reset();
        end else begin
            visible = m_pend & bus.mask;
            acked   = m_busy && bus.disp_ack;
            nxt     = m_pend;
            if (acked) nxt[m_idx] = 1'b0;
            if (bus.sw_clr_vld) nxt[bus.sw_clr_idx] = 1'b0;
            nxt = nxt | bus.set_vec;
            m_to = 0;
            if (!m_busy) begin
                if (visible != 64'd0) begin
                    m_busy = 1;
                    m_idx  = top_bit(visible);
                    m_age  = 1;
                end
            end else if (acked) begin
                m_busy = 0;
            end else if (!bus.mask[m_idx] || !m_pend[m_idx]) begin
                m_busy = 0;
            end else if (TIMEOUT != 0 && m_age >= TIMEOUT) begin
                m_busy = 0;
                m_to   = 1;
            end else begin
                m_age++;
            end
            m_pend = nxt;
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        arst_l = 1'b0;
        drive_idle();
        model_reset();
        #12;
        n_checks++; if (bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL reset_vld: got %b want 0", bus.disp_vld); end
        n_checks++; if (bus.disp_idx !== 6'd0) begin n_errors++; $display("FAIL reset_idx: got %0d want 0", bus.disp_idx); end
        n_checks++; if (bus.pend_q !== 64'd0) begin n_errors++; $display("FAIL reset_pend: got %h want 0", bus.pend_q); end
        n_checks++; if (bus.to_pulse !== 1'b0) begin n_errors++; $display("FAIL reset_to: got %b want 0", bus.to_pulse); end
        n_checks++; if (bus.pend_any !== 1'b0) begin n_errors++; $display("FAIL reset_any: got %b want 0", bus.pend_any); end
        #1 arst_l = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL reset_idle_vld: got %b want 0", bus.disp_vld); end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        bus.set_vec  = 64'd1 << 17;
        bus.disp_ack = 1'b1;
        tick();
        bus.set_vec = '0;
        n_checks++; if (bus.pend_q !== (64'd1 << 17)) begin n_errors++; $display("FAIL single_pend1: got %h want %h", bus.pend_q, 64'd1 << 17); end
        n_checks++; if (bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL single_vld1: got %b want 0", bus.disp_vld); end
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1) begin n_errors++; $display("FAIL single_vld2: got %b want 1", bus.disp_vld); end
        n_checks++; if (bus.disp_idx !== 6'd17) begin n_errors++; $display("FAIL single_idx2: got %0d want 17", bus.disp_idx); end
        tick();
        n_checks++; if (bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL single_vld3: got %b want 0", bus.disp_vld); end
        n_checks++; if (bus.pend_q !== 64'd0) begin n_errors++; $display("FAIL single_pend3: got %h want 0", bus.pend_q); end
        bus.disp_ack = 1'b0;
        $display("test_single: dispatched idx 17");
    endtask

    task automatic test_priority();
        bus.set_vec  = (64'd1 << 5) | (64'd1 << 40);
        bus.disp_ack = 1'b1;
        tick();
        bus.set_vec = '0;
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd40) begin n_errors++; $display("FAIL prio_first: got vld=%b idx=%0d want vld=1 idx=40", bus.disp_vld, bus.disp_idx); end
        tick();
        n_checks++; if (bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL prio_gap: got %b want 0", bus.disp_vld); end
        n_checks++; if (bus.pend_q !== (64'd1 << 5)) begin n_errors++; $display("FAIL prio_pend3: got %h want %h", bus.pend_q, 64'd1 << 5); end
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd5) begin n_errors++; $display("FAIL prio_second: got vld=%b idx=%0d want vld=1 idx=5", bus.disp_vld, bus.disp_idx); end
        tick();
        n_checks++; if (bus.pend_q !== 64'd0 || bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL prio_end: got pend=%h vld=%b want 0/0", bus.pend_q, bus.disp_vld); end
        bus.disp_ack = 1'b0;
        $display("test_priority: dispatched 40 then 5");
    endtask

    task automatic test_collision();
        bus.set_vec = 64'd1 << 9;
        tick();
        bus.set_vec = '0;
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd9) begin n_errors++; $display("FAIL coll_req: got vld=%b idx=%0d want 1/9", bus.disp_vld, bus.disp_idx); end
        bus.disp_ack = 1'b1;
        bus.set_vec  = 64'd1 << 9;
        tick();
        bus.disp_ack = 1'b0;
        bus.set_vec  = '0;
        n_checks++; if (bus.pend_q[9] !== 1'b1) begin n_errors++; $display("FAIL coll_keep: got %b want 1", bus.pend_q[9]); end
        n_checks++; if (bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL coll_vld0: got %b want 0", bus.disp_vld); end
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd9) begin n_errors++; $display("FAIL coll_redisp: got vld=%b idx=%0d want 1/9", bus.disp_vld, bus.disp_idx); end
        bus.disp_ack = 1'b1;
        tick();
        bus.disp_ack = 1'b0;
        n_checks++; if (bus.pend_q !== 64'd0) begin n_errors++; $display("FAIL coll_clean: got %h want 0", bus.pend_q); end
        $display("test_collision: idx 9 kept and redispatched");
    endtask

    task automatic test_mask_withdraw();
        bus.set_vec = 64'd1 << 63;
        tick();
        bus.set_vec = '0;
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd63) begin n_errors++; $display("FAIL mask_req: got vld=%b idx=%0d want 1/63", bus.disp_vld, bus.disp_idx); end
        bus.mask[63] = 1'b0;
        tick();
        n_checks++; if (bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL mask_wd_vld: got %b want 0", bus.disp_vld); end
        n_checks++; if (bus.pend_q[63] !== 1'b1) begin n_errors++; $display("FAIL mask_wd_pend: got %b want 1", bus.pend_q[63]); end
        n_checks++; if (bus.to_pulse !== 1'b0) begin n_errors++; $display("FAIL mask_wd_to: got %b want 0", bus.to_pulse); end
        n_checks++; if (bus.pend_any !== 1'b0) begin n_errors++; $display("FAIL mask_any: got %b want 0", bus.pend_any); end
        // Ack with nothing outstanding must not clear anything.
        bus.disp_ack = 1'b1;
        tick();
        bus.disp_ack = 1'b0;
        n_checks++; if (bus.pend_q[63] !== 1'b1 || bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL stray_ack: got pend=%b vld=%b want 1/0", bus.pend_q[63], bus.disp_vld); end
        bus.mask = '1;
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd63) begin n_errors++; $display("FAIL mask_redisp: got vld=%b idx=%0d want 1/63", bus.disp_vld, bus.disp_idx); end
        bus.disp_ack = 1'b1;
        tick();
        bus.disp_ack = 1'b0;
        n_checks++; if (bus.pend_q !== 64'd0) begin n_errors++; $display("FAIL mask_clean: got %h want 0", bus.pend_q); end
        $display("test_mask_withdraw: idx 63 withdrawn and redispatched");
    endtask

    task automatic test_sw_clear();
        bus.set_vec = 64'd1 << 20;
        tick();
        bus.set_vec = '0;
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd20) begin n_errors++; $display("FAIL swclr_req: got vld=%b idx=%0d want 1/20", bus.disp_vld, bus.disp_idx); end
        bus.sw_clr_vld = 1'b1;
        bus.sw_clr_idx = 6'd20;
        tick();
        bus.sw_clr_vld = 1'b0;
        n_checks++; if (bus.pend_q[20] !== 1'b0 || bus.disp_vld !== 1'b1) begin n_errors++; $display("FAIL swclr_bit: got pend=%b vld=%b want 0/1", bus.pend_q[20], bus.disp_vld); end
        tick();
        n_checks++; if (bus.disp_vld !== 1'b0 || bus.to_pulse !== 1'b0) begin n_errors++; $display("FAIL swclr_wd: got vld=%b to=%b want 0/0", bus.disp_vld, bus.to_pulse); end
        tick();
        n_checks++; if (bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL swclr_idle: got %b want 0", bus.disp_vld); end
        $display("test_sw_clear: idx 20 withdrawn by software clear");
    endtask

    task automatic test_timeout();
        bus.set_vec = 64'd1 << 3;
        tick();
        bus.set_vec = '0;
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd3) begin n_errors++; $display("FAIL to_req: got vld=%b idx=%0d want 1/3", bus.disp_vld, bus.disp_idx); end
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            tick();
            n_checks++; if (bus.disp_vld !== 1'b1 || bus.to_pulse !== 1'b0) begin n_errors++; $display("FAIL to_hold%0d: got vld=%b to=%b want 1/0", k, bus.disp_vld, bus.to_pulse); end
        end
        tick();
        n_checks++; if (bus.disp_vld !== 1'b0 || bus.to_pulse !== 1'b1) begin n_errors++; $display("FAIL to_fire: got vld=%b to=%b want 0/1", bus.disp_vld, bus.to_pulse); end
        n_checks++; if (bus.pend_q[3] !== 1'b1) begin n_errors++; $display("FAIL to_pend: got %b want 1", bus.pend_q[3]); end
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd3 || bus.to_pulse !== 1'b0) begin n_errors++; $display("FAIL to_redisp: got vld=%b idx=%0d to=%b want 1/3/0", bus.disp_vld, bus.disp_idx, bus.to_pulse); end
        bus.disp_ack = 1'b1;
        tick();
        bus.disp_ack = 1'b0;
        n_checks++; if (bus.pend_q !== 64'd0) begin n_errors++; $display("FAIL to_clean: got %h want 0", bus.pend_q); end
        $display("test_timeout: idx 3 timed out and redispatched");
    endtask

    task automatic test_async_reset();
        bus.set_vec = (64'd1 << 50) | (64'd1 << 7);
        tick();
        bus.set_vec = '0;
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd50) begin n_errors++; $display("FAIL arst_req: got vld=%b idx=%0d want 1/50", bus.disp_vld, bus.disp_idx); end
        #2 arst_l = 1'b0;
        #1;
        n_checks++; if (bus.disp_vld !== 1'b0 || bus.disp_idx !== 6'd0) begin n_errors++; $display("FAIL arst_disp: got vld=%b idx=%0d want 0/0", bus.disp_vld, bus.disp_idx); end
        n_checks++; if (bus.pend_q !== 64'd0) begin n_errors++; $display("FAIL arst_pend: got %h want 0", bus.pend_q); end
        model_reset();
        #1 arst_l = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL arst_quiet%0d: got %b want 0", k, bus.disp_vld); end
        end
        bus.set_vec = 64'd1 << 12;
        tick();
        bus.set_vec = '0;
        tick();
        n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'd12) begin n_errors++; $display("FAIL arst_new: got vld=%b idx=%0d want 1/12", bus.disp_vld, bus.disp_idx); end
        bus.disp_ack = 1'b1;
        tick();
        bus.disp_ack = 1'b0;
        $display("test_async_reset: cleared mid-request, new dispatch idx 12");
    endtask

    task automatic test_back_to_back();
        bus.set_vec  = '1;
        bus.disp_ack = 1'b1;
        tick();
        bus.set_vec = '0;
        for (int k = 63; k >= 0; k--) begin
            tick();
            n_checks++; if (bus.disp_vld !== 1'b1 || bus.disp_idx !== 6'(k)) begin n_errors++; $display("FAIL b2b_disp%0d: got vld=%b idx=%0d want 1/%0d", k, bus.disp_vld, bus.disp_idx, k); end
            tick();
            n_checks++; if (bus.disp_vld !== 1'b0) begin n_errors++; $display("FAIL b2b_gap%0d: got %b want 0", k, bus.disp_vld); end
        end
        bus.disp_ack = 1'b0;
        n_checks++; if (bus.pend_q !== 64'd0) begin n_errors++; $display("FAIL b2b_clean: got %h want 0", bus.pend_q); end
        $display("test_back_to_back: 64 dispatches 63..0");
    endtask

    task automatic test_random();
        int nb;
        int r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.set_vec = '0;
            if ($urandom_range(0, 3) == 0) begin
                nb = int'($urandom_range(1, 3));
                for (int j = 0; j < nb; j++) begin
                    r = int'($urandom_range(0, 63));
                    bus.set_vec[r] = 1'b1;
                end
            end
            bus.sw_clr_vld = ($urandom_range(0, 9) == 0);
            bus.sw_clr_idx = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, 63));
                bus.mask[r] = ~bus.mask[r];
            end
            if ($urandom_range(0, 31) == 0) bus.mask = '1;
            bus.disp_ack = ($urandom_range(0, 99) < 35);
            if (bus.disp_vld && bus.disp_ack) $display("rand cycle %0d: ack idx %0d", cyc, bus.disp_idx);
            tick();
            n_checks++; if (bus.disp_vld !== m_busy) begin n_errors++; $display("FAIL rand_vld c%0d: got %b want %b", cyc, bus.disp_vld, m_busy); end
            if (m_busy) begin
                n_checks++; if (bus.disp_idx !== 6'(m_idx)) begin n_errors++; $display("FAIL rand_idx c%0d: got %0d want %0d", cyc, bus.disp_idx, m_idx); end
            end
            n_checks++; if (bus.pend_q !== m_pend) begin n_errors++; $display("FAIL rand_pend c%0d: got %h want %h", cyc, bus.pend_q, m_pend); end
            n_checks++; if (bus.to_pulse !== m_to) begin n_errors++; $display("FAIL rand_to c%0d: got %b want %b", cyc, bus.to_pulse, m_to); end
            n_checks++; if (bus.pend_vec !== (m_pend & bus.mask)) begin n_errors++; $display("FAIL rand_vec c%0d: got %h want %h", cyc, bus.pend_vec, m_pend & bus.mask); end
            n_checks++; if (bus.pend_any !== ((m_pend & bus.mask) != 64'd0)) begin n_errors++; $display("FAIL rand_any c%0d: got %b want %b", cyc, bus.pend_any, (m_pend & bus.mask) != 64'd0); end
        end
        drive_idle();
        $display("test_random: 400 cycles");
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_collision();
        test_mask_withdraw();
        test_sw_clear();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sparc_tlu_intpend64.md
Name: sparc_tlu_intpend64

Overview:
- 64-entry pending-interrupt holding register with dispatch sequencer.
- Sits directly upstream of the 64->6 priority encoder in the TLU: drives the masked pending vector into it, takes back the encoded index (bit 63 = highest priority), and presents one winner at a time to the trap logic over a valid/ack handshake.
- Clears the serviced bit on ack. Withdraws requests that are masked off or left unacknowledged too long.

Parameters:
ACK_TIMEOUT, 0, cycles disp_vld may stay unacknowledged before withdrawal; 0 disables timeout.
TO_W, 8, width of timeout counter; ACK_TIMEOUT must be < 2^TO_W.

Ports:
rclk  in  1  clock
arst_l  in  1  asynchronous active-low reset
set_vec  in  64  per-bit set requests, one cycle each, may be multi-hot
sw_clr_vld  in  1  software clear strobe
sw_clr_idx  in  6  bit index cleared when sw_clr_vld=1
mask  in  64  per-bit enable; only enabled bits compete
pend_vec  out  64  pend_q & mask, combinational, feeds the encoder input
penc_idx  in  6  encoder result for pend_vec, same cycle
pend_q  out  64  raw pending register
pend_any  out  1  |pend_vec
disp_vld  out  1  dispatch request, registered
disp_idx  out  6  index being dispatched, registered, stable while disp_vld=1
disp_ack  in  1  trap logic accepts; only meaningful when disp_vld=1
to_pulse  out  1  one-cycle pulse on timeout withdrawal

Behaviour:
- Reset (arst_l=0, async) forces pend_q=0, state=IDLE, disp_vld=0, disp_idx=0, to_pulse=0, counter=0. Effect is immediate and overrides everything, including mid-REQ.
- pend_q next-state, per bit i: set_vec[i] | (pend_q[i] & ~clr[i]).
  - clr[i] = (ack_clr & disp_idx==i) | (sw_clr_vld & sw_clr_idx==i).
  - ack_clr = (state==REQ) & disp_ack.
  - Set wins over any simultaneous clear of the same bit, so no event is lost.
- FSM states: IDLE, REQ.
  - IDLE: if pend_any=1, capture disp_idx<=penc_idx, go REQ, disp_vld<=1, counter<=0. Otherwise stay.
  - REQ, disp_ack=1: clear pend_q[disp_idx], disp_vld<=0, go IDLE.
  - REQ, ~mask[disp_idx] or pend_q[disp_idx]==0 (e.g. sw clear): withdraw. disp_vld<=0, go IDLE, no pend change. Ack in the same cycle takes precedence over withdrawal.
  - REQ, ACK_TIMEOUT!=0 and counter==ACK_TIMEOUT-1 with no ack: withdraw, to_pulse<=1 for one cycle, bit stays pending. Otherwise counter increments.
- No re-arbitration while in REQ. A higher-priority arrival waits until the current request is acked or withdrawn.
- Latency:
  - set_vec in cycle N -> pend_q in N+1 -> disp_vld in N+2.
  - Ack in cycle M -> bit clear and disp_vld=0 in M+1.
  - Next disp_vld earliest in M+2 (IDLE evaluates the updated pend_q in M+1).
- disp_ack while disp_vld=0 is ignored.
- All 64 bits set: dispatch order 63,62,...,0, one every 2 cycles with immediate ack.
- penc_idx is trusted only when pend_any=1. The block never dispatches with pend_any=0.

Test Plan:
- Single event: set_vec bit 17 at cycle 0, ack held high -> disp_vld=1, disp_idx=17 at cycle 2. pend_q[17]=0 at cycle 3. disp_vld=0 at cycle 3.
- Priority: set bits 5 and 40 together, immediate ack -> dispatches 40 then 5, disp_vld pulses at cycles 2 and 4, pend_q=0 after cycle 5.
- Set/clear collision: during REQ on bit 9, assert disp_ack and set_vec[9] in the same cycle -> pend_q[9] stays 1, second dispatch of 9 at M+2.
- Mask withdrawal: REQ on bit 63, drop mask[63] -> disp_vld=0 next cycle, pend_q[63] still 1, to_pulse=0. Re-enable mask -> redispatch of 63.
- Timeout (ACK_TIMEOUT=4): REQ on bit 3, no ack -> disp_vld high 4 cycles, then to_pulse=1 for 1 cycle, pend_q[3]=1, redispatch 2 cycles later.
- Async reset mid-REQ: pulse arst_l low between clock edges -> disp_vld, disp_idx, pend_q cleared immediately. After release, no dispatch until a new set_vec arrives.
